branch_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters, replacing fixed "resolve in MEM, flush IF/ID/EX" branch handling.
- IF stage looks up the fetch PC in the same cycle and gets predicted direction and target.
- EX/MEM stage returns resolved outcomes for training.
- Also keeps a saturating mispredict statistic for the bench and for performance debug.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bp_entry_array.sv | 49 ++++
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encoding, saturating counter and PC field helpers for branch_predictor
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

    // Callers size-cast the result down to IDX_W / TAG_W.
    function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w,
                                           input int unsigned tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_entry_array.sv
// rtl/bp_entry_array.sv - BTB storage: two combinational read ports, one write port, bulk invalidate
module bp_entry_array
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 8,
    parameter int PC_W    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [IDX_W-1:0]         lk_idx_i,
    output logic [TAG_W+PC_W+2:0]    lk_entry_o,
    input  logic [IDX_W-1:0]         up_idx_i,
    output logic [TAG_W+PC_W+2:0]    up_entry_o,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [TAG_W+PC_W+2:0]    wr_entry_i
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       cnt;
    } entry_t;

    entry_t mem [ENTRIES];

    // Flush only drops valid bits; a write in the same cycle is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en_i) begin
            mem[wr_idx_i] <= entry_t'(wr_entry_i);
        end
    end

    assign lk_entry_o = mem[lk_idx_i];
    assign up_entry_o = mem[up_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB with 2-bit direction counters; BP_GSHARE_EN selects a gshare direction table
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32,
    parameter int TAG_W   = 8,
    parameter int STAT_W  = 16,
    parameter int GHR_W   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PC_W-1:0]   lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [PC_W-1:0]   pred_target_o,
    output logic [GHR_W-1:0]  pred_ghr_o,
    input  logic              flush_i,
    input  logic              update_valid_i,
    input  logic [PC_W-1:0]   update_pc_i,
    input  logic              update_taken_i,
    input  logic [PC_W-1:0]   update_target_i,
    input  logic              update_mispred_i,
    input  logic [GHR_W-1:0]  update_ghr_i,
    output logic [STAT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       cnt;
    } entry_t;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    entry_t           lk_e, up_e, wr_e;
    logic             wr_en;
    logic             lk_hit, up_hit, lk_dir;
    logic [STAT_W-1:0] mispred_q;

    assign lk_idx = IDX_W'(pc_idx(64'(lookup_pc_i), IDX_W));
    assign lk_tag = TAG_W'(pc_tag(64'(lookup_pc_i), IDX_W, TAG_W));
    assign up_idx = IDX_W'(pc_idx(64'(update_pc_i), IDX_W));
    assign up_tag = TAG_W'(pc_tag(64'(update_pc_i), IDX_W, TAG_W));

    bp_entry_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .PC_W    (PC_W)
    ) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .lk_idx_i   (lk_idx),
        .lk_entry_o (lk_e),
        .up_idx_i   (up_idx),
        .up_entry_o (up_e),
        .wr_en_i    (wr_en),
        .wr_idx_i   (up_idx),
        .wr_entry_i (wr_e)
    );

    assign lk_hit = lk_e.valid && (lk_e.tag == lk_tag);
    assign up_hit = up_e.valid && (up_e.tag == up_tag);

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [1:0]       pht_q [ENTRIES];
    logic [IDX_W-1:0] pht_up_idx;
    logic             unused_cnt;

    assign pht_up_idx = up_idx ^ IDX_W'(update_ghr_i);
    assign lk_dir     = pht_q[lk_idx ^ IDX_W'(ghr_q)][1];
    assign pred_ghr_o = ghr_q;
    assign unused_cnt = ^lk_e.cnt;

    // History is non-speculative and survives flushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= WNT;
            end
        end else if (update_valid_i && !flush_i) begin
            ghr_q             <= GHR_W'({ghr_q, update_taken_i});
            pht_q[pht_up_idx] <= cnt_next(pht_q[pht_up_idx], update_taken_i);
        end
    end
`else
    logic unused_ghr;

    assign lk_dir     = lk_e.cnt[1];
    assign pred_ghr_o = '0;
    assign unused_ghr = ^update_ghr_i;
`endif

    assign pred_hit_o    = lk_hit;
    assign pred_taken_o  = lk_hit && lk_dir;
    assign pred_target_o = pred_taken_o ? lk_e.target : lookup_pc_i + PC_W'(4);

    // Allocation on a miss only for taken branches; not-taken misses leave the slot alone.
    always_comb begin
        wr_e  = up_e;
        wr_en = 1'b0;
        if (update_valid_i) begin
            if (up_hit) begin
                wr_en    = 1'b1;
                wr_e.cnt = cnt_next(up_e.cnt, update_taken_i);
                if (update_taken_i) begin
                    wr_e.target = update_target_i;
                end
            end else if (update_taken_i) begin
                wr_en = 1'b1;
                wr_e  = '{valid: 1'b1, tag: up_tag, target: update_target_i, cnt: WT};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mispred_q <= '0;
        end else if (update_valid_i && update_mispred_i && (mispred_q != '1)) begin
            mispred_q <= mispred_q + STAT_W'(1);
        end
    end

    assign mispred_cnt_o = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed bench for branch_predictor (default and STAT_W=4 instances)
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        flush;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispred;
    logic [5:0]  update_ghr;

    logic        hit, taken, hit4, taken4;
    logic [31:0] target, target4;
    logic [5:0]  ghr, ghr4;
    logic [15:0] mcnt;
    logic [3:0]  mcnt4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .lookup_pc_i      (lookup_pc),
        .pred_hit_o       (hit),
        .pred_taken_o     (taken),
        .pred_target_o    (target),
        .pred_ghr_o       (ghr),
        .flush_i          (flush),
        .update_valid_i   (update_valid),
        .update_pc_i      (update_pc),
        .update_taken_i   (update_taken),
        .update_target_i  (update_target),
        .update_mispred_i (update_mispred),
        .update_ghr_i     (update_ghr),
        .mispred_cnt_o    (mcnt)
    );

    branch_predictor #(.STAT_W(4)) dut4 (
        .clk_i            (clk),
        .rst_i            (rst),
        .lookup_pc_i      (lookup_pc),
        .pred_hit_o       (hit4),
        .pred_taken_o     (taken4),
        .pred_target_o    (target4),
        .pred_ghr_o       (ghr4),
        .flush_i          (flush),
        .update_valid_i   (update_valid),
        .update_pc_i      (update_pc),
        .update_taken_i   (update_taken),
        .update_target_i  (update_target),
        .update_mispred_i (update_mispred),
        .update_ghr_i     (update_ghr),
        .mispred_cnt_o    (mcnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
        update_valid   = 1'b1;
        update_pc      = pc;
        update_taken   = tk;
        update_target  = tgt;
        update_mispred = mp;
        tick();
        update_valid   = 1'b0;
        update_mispred = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
        update_target = '0; update_mispred = 1'b0; update_ghr = 6'h2a; lookup_pc = 32'h40;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_hit",    32'(hit),    32'h0);
        check("rst_taken",  32'(taken),  32'h0);
        check("rst_target", target,      32'h44);
        check("rst_ghr",    32'(ghr),    32'h0);
        check("rst_mcnt",   32'(mcnt),   32'h0);
        check("rst_mcnt4",  32'(mcnt4),  32'h0);

        upd(32'h40, 1'b1, 32'h100, 1'b0);
        #1;
        check("alloc_hit",    32'(hit),   32'h1);
        check("alloc_taken",  32'(taken), 32'h1);
        check("alloc_target", target,     32'h100);

        upd(32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        #1;
        check("nt2_hit",    32'(hit),   32'h1);
        check("nt2_taken",  32'(taken), 32'h0);
        check("nt2_target", target,     32'h44);

        lookup_pc = 32'h140;
        #1;
        check("alias_hit",    32'(hit), 32'h0);
        check("alias_target", target,   32'h144);
        upd(32'h140, 1'b0, 32'h500, 1'b0);
        lookup_pc = 32'h40;
        #1;
        check("nt_miss_keep", 32'(hit), 32'h1);

        repeat (5) upd(32'h40, 1'b1, 32'h100, 1'b0);
        #1;
        check("sat_taken", 32'(taken), 32'h1);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        #1;
        check("st_nt_taken", 32'(taken), 32'h1);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        #1;
        check("wt_nt_taken", 32'(taken), 32'h0);

        upd(32'h40, 1'b1, 32'h180, 1'b0);
        #1;
        check("retarget_taken",  32'(taken), 32'h1);
        check("retarget_target", target,     32'h180);

        update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b0;
        #1;
        check("same_cyc_pre", 32'(taken), 32'h1);
        tick();
        update_valid = 1'b0;
        #1;
        check("same_cyc_post", 32'(taken), 32'h0);

        flush = 1'b1; update_valid = 1'b1; update_pc = 32'h80; update_taken = 1'b1; update_target = 32'h200;
        tick();
        flush = 1'b0; update_valid = 1'b0;
        lookup_pc = 32'h40;
        #1;
        check("flush_hit_40", 32'(hit), 32'h0);
        lookup_pc = 32'h80;
        #1;
        check("flush_hit_80", 32'(hit), 32'h0);

        upd(32'h80, 1'b1, 32'h200, 1'b0);
        #1;
        check("realloc_hit",    32'(hit), 32'h1);
        check("realloc_target", target,   32'h200);

        lookup_pc = 32'hffff_fffc;
        #1;
        check("wrap_target", target, 32'h0);

        update_mispred = 1'b1;
        tick();
        update_mispred = 1'b0;
        #1;
        check("mp_no_valid", 32'(mcnt), 32'h0);

        repeat (17) upd(32'h1000, 1'b0, 32'h0, 1'b1);
        #1;
        check("mcnt4_sat", 32'(mcnt4), 32'hf);
        check("mcnt_17",   32'(mcnt),  32'd17);

        rst = 1'b1; update_valid = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
        update_target = 32'h300; update_mispred = 1'b1;
        tick();
        rst = 1'b0; update_valid = 1'b0; update_mispred = 1'b0;
        lookup_pc = 32'h40;
        #1;
        check("midrst_hit",    32'(hit),   32'h0);
        check("midrst_target", target,     32'h44);
        check("midrst_mcnt",   32'(mcnt),  32'h0);
        check("midrst_mcnt4",  32'(mcnt4), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
